radial_lens_distortion: RTL and testbench
=========================================

// Module: radial_lens_distortion
// PURPOSE
//  Frame-buffered radial lens remapper, successor to the fixed barrel block; sits between capture and display.
//  Stores one frame, then reads it back in raster order through a source-coordinate map:
//  src = C + d*F(r^2), with d = output pixel minus centre C.
//  Generalised over the fixed block: runtime coefficient, per-frame mode (bypass/barrel/pincushion),
//  fill colour, and ready/valid on both sides with output backpressure.
// PARAMETERS
//  WIDTH       320    pixels per line (>=2)
//  HEIGHT      466    lines per frame (>=2)
//  DATA_WIDTH  24     bits per pixel
//  K_SHIFT     4      right shift applied to r^2*k1 before adding to Q16 unity
//  CX          WIDTH/2   distortion centre x
//  CY          HEIGHT/2  distortion centre y
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           asynchronous, active-low reset
//  cfg_k1     in   8           unsigned coefficient, sampled at frame start
//  cfg_mode   in   2           0=bypass 1=barrel 2=pincushion 3=bypass; sampled at frame start
//  cfg_fill   in   DATA_WIDTH  value output for out-of-range sources; sampled at frame start
//  s_data     in   DATA_WIDTH  input pixel
//  s_valid    in   1           input pixel valid
//  s_ready    out  1           block accepts input pixel
//  s_sof      in   1           first pixel of frame (qualified by s_valid&&s_ready)
//  s_eof      in   1           last pixel of frame (qualified)
//  m_data     out  DATA_WIDTH  output pixel
//  m_valid    out  1           output pixel valid
//  m_ready    in   1           downstream accepts output
//  m_sof      out  1           with first output pixel
//  m_eof      out  1           with last output pixel
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, shadow cfg = 0 (bypass), pipeline flushed, buffer contents undefined.
//  FSM IDLE -> RECV -> PROC -> IDLE. s_ready = 1 in IDLE and RECV only.
//   IDLE: accepted beat without s_sof is dropped. Beat with s_sof is written to (0,0); shadow k1/mode/fill latched; go RECV.
//   RECV: each accepted beat is written at (in_x,in_y); raster increment, x wraps at WIDTH-1.
//    Go PROC after the beat at (WIDTH-1,HEIGHT-1), or after any beat with s_eof (early end).
//    Early end: unwritten locations keep previous-frame contents.
//    Beat with s_sof in RECV restarts the write at (0,0) and re-latches cfg.
//   PROC: issue output coords (ox,oy) in raster order into a 5-stage pipeline:
//    dx/dy -> r^2 -> F -> src -> buffer read.
//    Latency issue->m_valid is 5 cycles. Output starts 5 cycles after entering PROC.
//    Return to IDLE when the (WIDTH-1,HEIGHT-1) pixel is accepted (m_valid&&m_ready).
//  Backpressure: m_valid && !m_ready stalls the whole pipeline and the coordinate counter.
//   m_data/m_sof/m_eof hold stable while stalled. No pixel is dropped or duplicated.
//  Arithmetic (signed, floor shifts):
//   dx=ox-CX, dy=oy-CY (17b); r2=dx*dx+dy*dy (32b); T=(r2*k1)>>>K_SHIFT.
//   F = 65536+T (barrel), max(65536-T,0) (pincushion).
//   src_x = CX+((dx*F)>>>16), src_y = CY+((dy*F)>>>16), 48b products.
//   Bypass: src = (ox,oy).
//  Range: src_x<0 || src_x>=WIDTH || src_y<0 || src_y>=HEIGHT -> m_data=fill_shadow.
//  m_sof on pixel (0,0), m_eof on (WIDTH-1,HEIGHT-1). Both at most one beat per frame.
//  Input arriving during PROC is not accepted (s_ready=0).
//  rst_n mid-frame: immediate return to IDLE, m_valid=0, partial output abandoned.
// TESTING  (WIDTH=8, HEIGHT=6, K_SHIFT=0, CX=4, CY=3, pixel value = y*8+x)
//  1 Bypass, m_ready=1: 48 beats in -> 48 beats out identical in order, m_sof on first, m_eof on 48th,
//    first m_valid 5 cycles after entering PROC.
//  2 Barrel, k1=64, fill=0xABCDEF:
//    out(0,0) -> 0xABCDEF (src_x=-1); out(3,3) -> 26 (src 2,3); out(5,3) -> 29; out(4,3) -> 28.
//  3 Pincushion, k1=64: out(3,3) -> 27 (F=65472, src 3,3); out(4,3) -> 28.
//  4 Random m_ready (~50%) in barrel mode: output sequence equals the m_ready=1 run.
//    m_data stable during stalls. Exactly 48 beats out.
//  5 s_eof on beat 20: PROC starts after beat 20, 48 beats still output, unwritten pixels = previous frame.
//    Second s_sof mid-RECV restarts at (0,0).
//  6 rst_n low during PROC at output pixel 10: m_valid=0, busy=0 next cycle.
//    Next full bypass frame passes unchanged. cfg change mid-frame has no effect until next s_sof.

Source files
------------

// File: rtl/radial_lens_distortion.sv
// Frame-buffered radial remapper: store a frame, replay it through src = C + d*F(r^2).
// Latency 5 cycles issue->m_valid; m_valid && !m_ready freezes the whole read pipeline.
module radial_lens_distortion #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 466,
    parameter int DATA_WIDTH = 24,
    parameter int K_SHIFT    = 4,
    parameter int CX         = WIDTH / 2,
    parameter int CY         = HEIGHT / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            cfg_k1,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_fill,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_sof,
    input  logic                  s_eof,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic                  busy
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, PROC = 2'd2;

    logic [1:0]            state;
    logic [XW-1:0]         in_x, wr_x, ox, s1_ox, s2_ox, s3_ox;
    logic [YW-1:0]         in_y, wr_y, oy, s1_oy, s2_oy, s3_oy;
    logic [7:0]            k1_sh;
    logic [1:0]            mode_sh;
    logic [DATA_WIDTH-1:0] fill_sh, rd_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  issue_act, wr_en, wr_last, en, frame_done;
    logic [AW-1:0]         wr_addr, s4_addr, addr_c;
    logic                  s1_vld, s2_vld, s3_vld, s4_vld, s5_vld;
    logic                  s1_sof, s2_sof, s3_sof, s4_sof, s5_sof;
    logic                  s1_eof, s2_eof, s3_eof, s4_eof, s5_eof;
    logic                  s4_inr, s5_inr, inr_c;
    logic signed [16:0]    dx_c, dy_c, s1_dx, s1_dy, s2_dx, s2_dy, s3_dx, s3_dy;
    logic signed [31:0]    dx32, dy32, r2_c, s2_r2;
    logic signed [47:0]    prod_c, t_c, f_c, s3_f, px_c, py_c, sx_c, sy_c;

    assign s_ready    = (state == IDLE) || (state == RECV);
    assign wr_en      = s_valid && s_ready && (s_sof || state == RECV);
    assign wr_x       = s_sof ? '0 : in_x;
    assign wr_y       = s_sof ? '0 : in_y;
    assign wr_last    = s_eof || (wr_x == XW'(WIDTH - 1) && wr_y == YW'(HEIGHT - 1));
    assign wr_addr    = AW'(wr_y) * AW'(WIDTH) + AW'(wr_x);
    assign en         = !(s5_vld && !m_ready);
    assign frame_done = s5_vld && s5_eof && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_x      <= '0;
            in_y      <= '0;
            k1_sh     <= '0;
            mode_sh   <= '0;
            fill_sh   <= '0;
            ox        <= '0;
            oy        <= '0;
            issue_act <= 1'b0;
        end else if (wr_en) begin
            if (s_sof) begin
                k1_sh   <= cfg_k1;
                mode_sh <= cfg_mode;
                fill_sh <= cfg_fill;
            end
            if (wr_last) begin
                state     <= PROC;
                ox        <= '0;
                oy        <= '0;
                issue_act <= 1'b1;
            end else begin
                state <= RECV;
                if (wr_x == XW'(WIDTH - 1)) begin
                    in_x <= '0;
                    in_y <= wr_y + 1'b1;
                end else begin
                    in_x <= wr_x + 1'b1;
                    in_y <= wr_y;
                end
            end
        end else if (state == PROC) begin
            if (en && issue_act) begin
                if (ox == XW'(WIDTH - 1)) begin
                    ox <= '0;
                    oy <= oy + 1'b1;
                    if (oy == YW'(HEIGHT - 1))
                        issue_act <= 1'b0;
                end else begin
                    ox <= ox + 1'b1;
                end
            end
            if (frame_done)
                state <= IDLE;
        end
    end

    always_comb begin
        dx_c   = 17'(ox) - 17'(CX);
        dy_c   = 17'(oy) - 17'(CY);
        dx32   = 32'(s1_dx);
        dy32   = 32'(s1_dy);
        r2_c   = dx32 * dx32 + dy32 * dy32;
        prod_c = 48'(s2_r2) * $signed({40'd0, k1_sh});
        t_c    = prod_c >>> K_SHIFT;
        // pincushion gain clamps at zero instead of folding the image through the centre
        if (mode_sh == 2'd2)
            f_c = (t_c > 48'sd65536) ? 48'sd0 : 48'sd65536 - t_c;
        else
            f_c = 48'sd65536 + t_c;
        px_c = 48'(s3_dx) * s3_f;
        py_c = 48'(s3_dy) * s3_f;
        if (mode_sh == 2'd1 || mode_sh == 2'd2) begin
            sx_c = 48'(CX) + (px_c >>> 16);
            sy_c = 48'(CY) + (py_c >>> 16);
        end else begin
            sx_c = $signed(48'(s3_ox));
            sy_c = $signed(48'(s3_oy));
        end
        inr_c  = (sx_c >= 48'sd0) && (sx_c < 48'(WIDTH)) &&
                 (sy_c >= 48'sd0) && (sy_c < 48'(HEIGHT));
        addr_c = AW'(sy_c) * AW'(WIDTH) + AW'(sx_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_vld, s2_vld, s3_vld, s4_vld, s5_vld} <= '0;
            {s1_sof, s2_sof, s3_sof, s4_sof, s5_sof} <= '0;
            {s1_eof, s2_eof, s3_eof, s4_eof, s5_eof} <= '0;
            {s1_dx, s1_dy, s2_dx, s2_dy, s3_dx, s3_dy} <= '0;
            {s1_ox, s2_ox, s3_ox, s1_oy, s2_oy, s3_oy} <= '0;
            s2_r2   <= '0;
            s3_f    <= '0;
            s4_inr  <= 1'b0;
            s4_addr <= '0;
            s5_inr  <= 1'b0;
        end else if (en) begin
            s1_vld  <= issue_act;
            s1_sof  <= issue_act && ox == '0 && oy == '0;
            s1_eof  <= issue_act && ox == XW'(WIDTH - 1) && oy == YW'(HEIGHT - 1);
            s1_dx   <= dx_c;
            s1_dy   <= dy_c;
            s1_ox   <= ox;
            s1_oy   <= oy;
            s2_vld  <= s1_vld;
            s2_sof  <= s1_sof;
            s2_eof  <= s1_eof;
            s2_r2   <= r2_c;
            s2_dx   <= s1_dx;
            s2_dy   <= s1_dy;
            s2_ox   <= s1_ox;
            s2_oy   <= s1_oy;
            s3_vld  <= s2_vld;
            s3_sof  <= s2_sof;
            s3_eof  <= s2_eof;
            s3_f    <= f_c;
            s3_dx   <= s2_dx;
            s3_dy   <= s2_dy;
            s3_ox   <= s2_ox;
            s3_oy   <= s2_oy;
            s4_vld  <= s3_vld;
            s4_sof  <= s3_sof;
            s4_eof  <= s3_eof;
            s4_inr  <= inr_c;
            s4_addr <= addr_c;
            s5_vld  <= s4_vld;
            s5_sof  <= s4_sof;
            s5_eof  <= s4_eof;
            s5_inr  <= s4_inr;
        end
    end

    // frame store: writes only while receiving, reads only while processing
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= s_data;
        if (en)
            rd_q <= mem[s4_addr];
    end

    assign m_valid = s5_vld;
    assign m_sof   = s5_sof;
    assign m_eof   = s5_eof;
    assign m_data  = s5_inr ? rd_q : fill_sh;
    assign busy    = state != IDLE;
endmodule

// File: tb/tb_radial_lens_distortion.sv
// Bench for radial_lens_distortion on an 8x6 frame: table vectors plus random frames vs a model.
module tb_radial_lens_distortion;
    localparam int W = 8, H = 6, N = W * H, DW = 24, KS = 0, CXV = 4, CYV = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    cfg_k1 = '0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_fill = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0, s_sof = 1'b0, s_eof = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_sof, m_eof, busy;
    logic          m_ready = 1'b1;

    radial_lens_distortion #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .K_SHIFT(KS),
                             .CX(CXV), .CY(CYV)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_k1(cfg_k1), .cfg_mode(cfg_mode), .cfg_fill(cfg_fill),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_eof(s_eof),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eof(m_eof),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, passes = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {logic [DW-1:0] d; bit sof; bit eof;} beat_t;
    beat_t beats[$];
    bit            rnd_ready = 1'b0;
    int            first_vld = -1;
    bit            first_rdy;
    bit            prev_stall = 1'b0;
    logic [DW+1:0] prev_out;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_vld", m_valid, 1);
                chk("stall_hold_dat", {m_data, m_sof, m_eof}, prev_out);
            end
            if (m_valid) begin
                if (first_vld < 0) begin
                    first_vld = cyc;
                    first_rdy = s_ready;
                end
                if (m_ready) beats.push_back('{m_data, m_sof, m_eof});
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_data, m_sof, m_eof};
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // reference model: frame store contents and the configuration latched by the last s_sof
    int fb[N];
    int mpos = 0, mk1 = 0, mmode = 0, mfill = 0, accept_cyc = 0;
    bit mrecv = 1'b0;
    int src_pix[N];

    function automatic longint fdiv(input longint a, input longint d);
        longint q = a / d;
        if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint ref_pix(input int x, input int y);
        longint dx, dy, r2, t, f, sx, sy;
        if (mmode == 1 || mmode == 2) begin
            dx = x - CXV;
            dy = y - CYV;
            r2 = dx * dx + dy * dy;
            t  = fdiv(r2 * mk1, 64'd1 << KS);
            if (mmode == 1) f = 65536 + t;
            else            f = (65536 - t > 0) ? 65536 - t : 0;
            sx = CXV + fdiv(dx * f, 65536);
            sy = CYV + fdiv(dy * f, 65536);
        end else begin
            sx = x;
            sy = y;
        end
        if (sx < 0 || sx >= W || sy < 0 || sy >= H) return mfill;
        return fb[sy * W + sx];
    endfunction

    task automatic send_beat(input int d, input bit sof, input bit eof);
        bit ok = 1'b0;
        s_data = DW'(d); s_sof = sof; s_eof = eof; s_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        accept_cyc = cyc;
        if (ok && (sof || mrecv)) begin
            if (sof) begin
                mpos = 0; mk1 = cfg_k1; mmode = cfg_mode; mfill = cfg_fill;
            end
            fb[mpos] = d;
            if (mpos == N - 1 || eof) mrecv = 1'b0;
            else begin mpos++; mrecv = 1'b1; end
        end
    endtask

    task automatic send_frame(input int n, input int eof_at, input bit scramble);
        for (int i = 0; i < n; i++) begin
            send_beat(src_pix[i], i == 0, i == eof_at);
            if (scramble && i == 0) begin
                cfg_mode = 2'd1; cfg_k1 = 8'($urandom); cfg_fill = DW'($urandom);
            end
        end
    endtask

    task automatic check_output(input string name);
        longint e;
        for (int t = 0; t < 4000 && beats.size() < N; t++) @(negedge clk);
        if (beats.size() < N) chk({name, "_out_timeout"}, beats.size(), N);
        for (int i = 0; i < N && i < beats.size(); i++) begin
            e = ref_pix(i % W, i / W) * 4 + (i == 0 ? 2 : 0) + (i == N - 1 ? 1 : 0);
            chk($sformatf("%s_pix%0d", name, i), {beats[i].d, beats[i].sof, beats[i].eof}, e);
        end
        repeat (8) @(negedge clk);
        chk({name, "_beat_count"}, beats.size(), N);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    task automatic start_frame(input int m, input int k1, input int fill, input bit ident);
        cfg_mode = 2'(m); cfg_k1 = 8'(k1); cfg_fill = DW'(fill);
        for (int i = 0; i < N; i++) src_pix[i] = ident ? i : int'($urandom & 32'hFFFFFF);
        beats.delete();
        first_vld = -1;
    endtask

    typedef struct {int mode; int ox; int oy; longint exp;} vec_t;
    vec_t vt[6];

    task automatic run_vec_mode(input int m);
        start_frame(m, 64, 'hABCDEF, 1'b1);
        send_frame(N, N - 1, 1'b0);
        check_output(m == 1 ? "barrel" : "pincush");
        for (int v = 0; v < 6; v++)
            if (vt[v].mode == m && beats.size() >= N)
                chk($sformatf("vec_m%0d_%0d_%0d", m, vt[v].ox, vt[v].oy),
                    beats[vt[v].oy * W + vt[v].ox].d, vt[v].exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1, 0, 0, 'hABCDEF};
        vt[1] = '{1, 3, 3, 26};
        vt[2] = '{1, 5, 3, 29};
        vt[3] = '{1, 4, 3, 28};
        vt[4] = '{2, 3, 3, 27};
        vt[5] = '{2, 4, 3, 28};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_sof", m_sof, 0);
        chk("rst_m_eof", m_eof, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // a beat without s_sof while idle is dropped
        send_beat(5, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_drop_busy", busy, 0);

        start_frame(0, 0, 0, 1'b1);
        send_frame(N, N - 1, 1'b0);
        check_output("bypass");
        chk("latency", first_vld - accept_cyc, 5);
        chk("s_ready_in_proc", first_rdy, 0);

        run_vec_mode(1);
        run_vec_mode(2);

        rnd_ready = 1'b1;
        start_frame(1, 64, 'hABCDEF, 1'b1);
        send_frame(N, N - 1, 1'b0);
        check_output("barrel_bp");

        for (int f = 0; f < 4; f++) begin
            rnd_ready = 1'($urandom_range(0, 1));
            start_frame($urandom_range(0, 3), $urandom_range(0, 255), $urandom, 1'b0);
            send_frame(N, N - 1, 1'b0);
            check_output($sformatf("rand%0d", f));
        end

        // early end: unwritten locations keep the previous frame
        rnd_ready = 1'b0;
        start_frame(0, 0, 0, 1'b0);
        send_frame(20, 19, 1'b0);
        check_output("early_eof");

        // partial frame with barrel config, then a fresh s_sof restarts with bypass
        start_frame(1, 99, 0, 1'b0);
        send_frame(10, -1, 1'b0);
        start_frame(0, 0, 0, 1'b0);
        send_frame(N, N - 1, 1'b0);
        check_output("restart");

        start_frame(0, 0, 0, 1'b0);
        send_frame(N, N - 1, 1'b0);
        for (int t = 0; t < 2000 && beats.size() < 10; t++) @(negedge clk);
        chk("pre_reset_progress", beats.size() >= 10, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_m_valid", m_valid, 0);
        chk("midreset_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        mrecv = 1'b0;

        // cfg changes after s_sof must not affect this frame
        start_frame(0, 0, 0, 1'b0);
        send_frame(N, N - 1, 1'b1);
        check_output("post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
